// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | cpu_pkg - shared divider widths and divider state encoding      |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
package cpu_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------+
// | div_step - one restoring shift/trial-subtract step (comb)       |
// | Rev 1.0                                                         |
// +----------------------------------------------------------------+
module div_step
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_trial;
  logic             w_nonneg;
  logic             w_unused_msb;

  assign w_shift  = {rem, quo[WIDTH-1]};
  // Extra top bit acts as the borrow of the WIDTH+1-bit subtract.
  assign w_trial  = {1'b0, w_shift} - {2'b00, dmag};
  assign w_nonneg = ~w_trial[WIDTH+1];

  // A kept difference is always below dmag, so bit WIDTH is zero there.
  assign w_unused_msb = w_trial[WIDTH];

  assign rem_next = w_nonneg ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], w_nonneg};

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// +----------------------------------------------------------------+
// | div_seq - 32-step restoring divider, start/busy/done handshake  |
// | Optional macro DIVU_EN adds is_unsigned (divu). Rev 1.0         |
// +----------------------------------------------------------------+
module div_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIVU_EN
  input  logic             is_unsigned,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_t           r_state;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]     r_rem;
  logic [WIDTH-1:0]     r_quo;
  logic [WIDTH-1:0]     r_dmag;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_zero;

  logic                 w_uns;
  logic                 w_dvd_neg;
  logic                 w_dvs_neg;
  logic [WIDTH-1:0]     w_dvd_mag;
  logic [WIDTH-1:0]     w_dvs_mag;
  logic [WIDTH-1:0]     w_rem_nx;
  logic [WIDTH-1:0]     w_quo_nx;

`ifdef DIVU_EN
  assign w_uns = is_unsigned;
`else
  assign w_uns = 1'b0;
`endif

  // Unsigned operands skip magnitude conversion; clearing the signs also skips FIX correction.
  assign w_dvd_neg = ~w_uns & dividend[WIDTH-1];
  assign w_dvs_neg = ~w_uns & divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;

  div_step #(
    .WIDTH    (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .dmag     (r_dmag),
    .rem_next (w_rem_nx),
    .quo_next (w_quo_nx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= DIV_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dmag   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_zero   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            div_zero <= 1'b0;
            r_zero   <= (divisor == '0);
            if (divisor == '0) begin
              r_state <= DIV_DONE;
            end else begin
              r_rem   <= '0;
              r_quo   <= w_dvd_mag;
              r_dmag  <= w_dvs_mag;
              r_neg_q <= w_dvd_neg ^ w_dvs_neg;
              r_neg_r <= w_dvd_neg;
              r_cnt   <= DIV_CNT_W'(WIDTH - 1);
              r_state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == '0) begin
            r_state <= DIV_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DIV_FIX: begin
          lo      <= r_neg_q ? -r_quo : r_quo;
          hi      <= r_neg_r ? -r_rem : r_rem;
          r_state <= DIV_DONE;
        end
        DIV_DONE: begin
          // hi/lo are left untouched on divide-by-zero.
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= r_zero;
          r_state  <= DIV_IDLE;
        end
        default: r_state <= DIV_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
